// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: serialiser states, register
// offsets within the 16-byte block, and STATUS/CTRL bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [3:0] cnt);
    logic [31:0] w;
    w                      = '0;
    w[STAT_FULL]           = full;
    w[STAT_EMPTY]          = empty;
    w[STAT_BUSY]           = busy;
    w[STAT_OVF]            = ovf;
    w[STAT_CNT_LSB +: 4]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, so a pop can load the
// head word on the same edge. A push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// 8N1 UART transmitter on the core data bus: TXDATA pushes into a FIFO that the
// serialiser drains; STATUS/CTRL let firmware poll, clear overflow and gate output.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [2:0]  rw_type,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        tx,
  output logic        irq
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  tx_state_t   state_reg;
  logic [15:0] baud_reg;
  logic [2:0]  bit_reg;
  logic [7:0]  shift_reg;
  logic        tx_reg;
  logic        tx_en_reg;
  logic        irq_en_reg;
  logic        ovf_reg;

  logic          sel;
  logic [1:0]    offset;
  logic          wr_txdata, wr_status, wr_ctrl;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0]   count_ext;
  logic [3:0]    count_disp;
  logic          busy;
  logic          bit_done;
  logic          unused_bits;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = addr[3:2];
  assign wr_txdata = w_en & sel & (offset == OFF_TXDATA);
  assign wr_status = w_en & sel & (offset == OFF_STATUS);
  assign wr_ctrl   = w_en & sel & (offset == OFF_CTRL);
  assign busy      = (state_reg != ST_IDLE);
  assign bit_done  = (baud_reg == 16'd0);
  assign unused_bits = ^{rw_type, addr[1:0], din[31:8]};

  // Pops happen only from IDLE or on the final cycle of a stop bit.
  assign fifo_pop = tx_en_reg & ~fifo_empty &
                    ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & bit_done));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (din[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count_ext  = 32'(fifo_count);
  assign count_disp = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_reg  <= 1'b1;
      irq_en_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tx_en_reg  <= din[CTRL_TX_EN];
        irq_en_reg <= din[CTRL_IRQ_EN];
      end
      // A dropped byte outranks a same-cycle W1C so the event is never lost.
      if (wr_txdata & fifo_full & ~fifo_pop)
        ovf_reg <= 1'b1;
      else if (wr_status & din[STAT_OVF])
        ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fifo_pop) begin
            shift_reg <= fifo_dout;
            bit_reg   <= '0;
            baud_reg  <= BAUD_RELOAD;
            tx_reg    <= 1'b0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_reg  <= BAUD_RELOAD;
            tx_reg    <= shift_reg[0];
            state_reg <= ST_DATA;
          end else begin
            baud_reg <= baud_reg - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_reg <= BAUD_RELOAD;
            if (bit_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
              bit_reg   <= bit_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (fifo_pop) begin
              shift_reg <= fifo_dout;
              bit_reg   <= '0;
              baud_reg  <= BAUD_RELOAD;
              tx_reg    <= 1'b0;
              state_reg <= ST_START;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            baud_reg <= baud_reg - 16'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    dout = '0;
    if (r_en & sel) begin
      case (offset)
        OFF_STATUS: dout = status_word(fifo_full, fifo_empty, busy, ovf_reg, count_disp);
        OFF_CTRL:   dout = {30'd0, irq_en_reg, tx_en_reg};
        default:    dout = '0;
      endcase
    end
  end

  assign tx  = tx_reg;
  assign irq = irq_en_reg & fifo_empty & ~busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=4; checks register
// readback, cycle-exact 8N1 framing, overflow, irq and asynchronous reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_TX   = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  rw_type = 3'd2;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_en    (w_en),
    .r_en    (r_en),
    .addr    (addr),
    .rw_type (rw_type),
    .din     (din),
    .dout    (dout),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Store: drives at the falling edge, returns just after the capturing edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    w_en = 1'b1;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    $display("WR addr=0x%08h data=0x%08h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    r_en = 1'b1;
    #1;
    $display("RD addr=0x%08h data=0x%08h", a, dout);
    chk(tag, dout, exp);
    r_en = 1'b0;
  endtask

  // Called just after the edge that makes a byte poppable; samples every cycle.
  task automatic expect_frame(input logic [7:0] b, input bit pre, input bit chk_irq);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    if (pre) begin
      @(negedge clk);
      chk("tx_prestart", 32'(tx), 32'd1);
      if (chk_irq) chk("irq_prestart", 32'(irq), 32'd0);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("tx_%02h_c%0d", b, i), 32'(tx), 32'(fr[i/4]));
      if (chk_irq) chk($sformatf("irq_%02h_c%0d", b, i), 32'(irq), 32'd0);
    end
    $display("FRAME byte=0x%02h sampled", b);
  endtask

  initial begin
    int lows;

    // Reset state
    #23;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("idle_status", A_STAT, 32'h002);
    rd_chk("idle_ctrl", A_CTRL, 32'h001);
    rd_chk("txdata_reads0", A_TX, 32'h0);
    chk("idle_tx", 32'(tx), 32'd1);

    // Single frame, busy seen mid-frame
    fork
      wr(A_TX, 32'hA5);
      begin
        wait (w_en);
        @(posedge clk);
        expect_frame(8'hA5, 1'b1, 1'b0);
      end
      begin
        wait (w_en);
        repeat (20) @(posedge clk);
        #2;
        addr = A_STAT;
        r_en = 1'b1;
        #1;
        chk("busy_mid", dout, 32'h006);
        r_en = 1'b0;
      end
    join
    rd_chk("status_after_a5", A_STAT, 32'h002);
    chk("tx_after_a5", 32'(tx), 32'd1);

    // Back-to-back frames with no idle gap
    fork
      begin
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        wr(A_TX, 32'h33);
      end
      begin
        wait (w_en);
        @(posedge clk);
        expect_frame(8'h11, 1'b1, 1'b0);
        expect_frame(8'h22, 1'b0, 1'b0);
        expect_frame(8'h33, 1'b0, 1'b0);
      end
    join
    rd_chk("status_after_b2b", A_STAT, 32'h002);

    // Overflow with tx disabled, W1C, then drain in order
    wr(A_CTRL, 32'h0);
    for (int i = 1; i <= 6; i++) wr(A_TX, 32'(i));
    rd_chk("status_full_ovf", A_STAT, 32'h409);
    chk("tx_disabled", 32'(tx), 32'd1);
    wr(A_STAT, 32'h8);
    rd_chk("status_ovf_clr", A_STAT, 32'h401);
    fork
      wr(A_CTRL, 32'h1);
      begin
        wait (w_en);
        @(posedge clk);
        expect_frame(8'h01, 1'b1, 1'b0);
        expect_frame(8'h02, 1'b0, 1'b0);
        expect_frame(8'h03, 1'b0, 1'b0);
        expect_frame(8'h04, 1'b0, 1'b0);
      end
    join
    rd_chk("status_drained", A_STAT, 32'h002);

    // Interrupt
    wr(A_CTRL, 32'h3);
    @(negedge clk);
    chk("irq_empty", 32'(irq), 32'd1);
    rd_chk("ctrl_readback", A_CTRL, 32'h003);
    fork
      wr(A_TX, 32'h5A);
      begin
        wait (w_en);
        @(posedge clk);
        expect_frame(8'h5A, 1'b1, 1'b1);
      end
    join
    @(negedge clk);
    chk("irq_after_stop", 32'(irq), 32'd1);

    // Reset mid-frame discards queued data
    wr(A_CTRL, 32'h1);
    wr(A_TX, 32'h3C);
    wr(A_TX, 32'h77);
    repeat (10) @(posedge clk);
    #2;
    chk("tx_mid_frame", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("tx_async_rst", 32'(tx), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("status_post_rst", A_STAT, 32'h002);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_frame_post_rst", 32'(lows), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the core's data-memory bus, decoded alongside `data_memory` in `riscv_top`. Consumes the core's store/load signals (`w_en`, `r_en`, `ram_addr`, `wr_mem_data`, `rw_type`). Stores to its data register push bytes into a small FIFO, which an 8N1 serialiser drains onto `tx`. Loads return status and control so firmware can poll before writing.

## Interface
- `CLK_DIV`, 434: clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, 2..64.
- `BASE_ADDR`, 32'h0000_1000: register block base; bits [3:0] must be 0.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `w_en` in 1: store strobe from core.
- `r_en` in 1: load strobe from core.
- `addr` in 32: byte address (`ram_addr`).
- `rw_type` in 3: access size; ignored, every access is treated as a word access on lane 0.
- `din` in 32: store data; only [7:0] is used for TXDATA.
- `dout` out 32: load data; 0 when not selected or `r_en`=0.
- `tx` out 1: serial line, idle high.
- `irq` out 1: level interrupt, asserted when `CTRL.irq_en & fifo_empty & ~busy`.

## Operation
- Select: `sel = (addr[31:4] == BASE_ADDR[31:4])`. The offset is `addr[3:2]`.
- Offset 0, TXDATA (W): if `w_en & sel` and the FIFO is not full, push `din[7:0]`. If the FIFO is full, drop the byte and set `STATUS.ovf`. Reads of TXDATA return 0.
- Offset 1, STATUS (R/W1C):
  - [0] full, [1] empty, [2] busy (FSM not IDLE), [3] ovf (sticky).
  - [11:8] count (zero-extended; saturates at 15 display if deeper).
  - Writing 1 to bit 3 clears ovf.
- Offset 2, CTRL (R/W): [0] tx_en (reset 1), [1] irq_en (reset 0).
- Offset 3: reads 0; writes are ignored.
- `dout` is combinational from registered state: it is valid in the same cycle as `r_en & sel`.
- Serialiser FSM: IDLE → START → DATA → STOP → (START | IDLE).
  - IDLE: if `tx_en & ~empty`, pop the head into the shift register, clear the bit counter and go to START.
  - START: `tx`=0 for CLK_DIV cycles.
  - DATA: `tx`=shift[0], LSB first, 8 bits × CLK_DIV cycles each.
  - STOP: `tx`=1 for CLK_DIV cycles. At the end of STOP, if `tx_en & ~empty`, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Clearing `tx_en` mid-frame completes the current frame; no further pops occur.
- Baud counter: 16-bit, reloads to CLK_DIV-1 on every state/bit entry and counts down to 0.

## Timing
- Reset values: `tx`=1, `dout`=0, `irq`=0, FIFO empty, ovf=0, FSM IDLE, tx_en=1, irq_en=0.
- Reset mid-frame: `tx` returns high asynchronously and FIFO contents are discarded.
- Push latency: a byte written at edge k is visible in STATUS after edge k. The FSM pops at edge k+1, and `tx` falls after edge k+1 (1-cycle write-to-start-bit).
- Frame length is exactly 10×CLK_DIV cycles. Back-to-back frames have zero idle cycles.
- Simultaneous push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees a slot in the same cycle; ovf is not set.
- Push into an empty FIFO cannot be popped in the same cycle; the FIFO pointers wrap modulo FIFO_DEPTH.
- A W1C write to STATUS in the same cycle as an overflow event leaves ovf=1 (set wins).
- `w_en` and `r_en` together: the write takes effect at the edge, and `dout` shows the pre-edge value.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE/START/DATA/STOP), register offsets, and STATUS/CTRL bit indices.
- Sub-module `sync_fifo`, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count. It is reusable for a later RX block.
- The top instantiates `sync_fifo`, the register decode and the serialiser FSM. `riscv_top` muxes `rd_mem_data` between `data_memory` and this block on `sel`.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Reset, then idle: `tx`=1, STATUS reads 0x002 (empty), `irq`=0.
- Store 0xA5 to BASE:
  - `tx` falls 1 cycle later.
  - Bits 1,0,1,0,0,1,0,1 follow, each 4 cycles.
  - Stop bit high; total 40 cycles.
  - STATUS busy=1 during the frame, 0 after.
- Store 0x11, 0x22, 0x33 back-to-back: three frames in 120 contiguous cycles with no idle gap between the stop bit and the next start bit.
- Clear tx_en, store 6 bytes:
  - STATUS reads full=1, count=4, ovf=1.
  - Write STATUS=0x8: ovf=0.
  - Set tx_en: the 4 queued bytes are sent in order.
- Set irq_en=1 with the FIFO empty: `irq`=1. Store a byte: `irq`=0 until its stop bit completes, then 1.
- Assert `rst_n`=0 at cycle 10 of a frame: `tx`=1 immediately; after release, STATUS reads 0x002 and no further frame is sent.
